// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between the instruction and data requesters.
// An in-order ID FIFO steers each memory response back to the requester that issued it.
module riscv_mem_arbiter #(
   parameter int REQ_SZ   = 67,
   parameter int RESP_SZ  = 35,
   parameter int MAX_OUTS = 4
) (
   input  logic                       clk,
   input  logic                       reset,

   input  logic [REQ_SZ-1:0]          imemreq_msg,
   input  logic                       imemreq_val,
   output logic                       imemreq_rdy,
   output logic [RESP_SZ-1:0]         imemresp_msg,
   output logic                       imemresp_val,

   input  logic [REQ_SZ-1:0]          dmemreq_msg,
   input  logic                       dmemreq_val,
   output logic                       dmemreq_rdy,
   output logic [RESP_SZ-1:0]         dmemresp_msg,
   output logic                       dmemresp_val,

   output logic [REQ_SZ-1:0]          memreq_msg,
   output logic                       memreq_val,
   input  logic                       memreq_rdy,
   input  logic [RESP_SZ-1:0]         memresp_msg,
   input  logic                       memresp_val,

   output logic [$clog2(MAX_OUTS):0]  outs_count,
   output logic                       resp_err
);

   localparam int PTR_W = $clog2(MAX_OUTS);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   typedef enum logic {
      ID_IMEM = 1'b0,
      ID_DMEM = 1'b1
   } req_id_e;

   state_e              state_q;
   req_id_e             last_grant_q;
   req_id_e             hold_id_q;
   req_id_e             id_fifo_q [MAX_OUTS];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    count_d;
   logic                resp_err_q;

   logic                run;
   logic                full;
   req_id_e             grant;
   logic                grant_val;
   logic                fire;
   logic                pop;
   req_id_e             head_id;

   // reset is active-low: the block only operates while it is high.
   assign run  = reset;
   assign full = (count_q == CNT_W'(MAX_OUTS));

   // HOLD pins the grant until the offered request fires; otherwise the
   // lone valid requester wins, and a tie goes to whoever did not win last.
   always_comb begin
      grant = (last_grant_q == ID_IMEM) ? ID_DMEM : ID_IMEM;
      if (state_q == ST_HOLD) begin
         grant = hold_id_q;
      end else if (imemreq_val && !dmemreq_val) begin
         grant = ID_IMEM;
      end else if (dmemreq_val && !imemreq_val) begin
         grant = ID_DMEM;
      end
   end

   assign grant_val   = (grant == ID_IMEM) ? imemreq_val : dmemreq_val;
   assign memreq_msg  = (grant == ID_IMEM) ? imemreq_msg : dmemreq_msg;
   assign memreq_val  = run && grant_val && !full;
   assign imemreq_rdy = run && memreq_rdy && !full && (grant == ID_IMEM);
   assign dmemreq_rdy = run && memreq_rdy && !full && (grant == ID_DMEM);
   assign fire        = memreq_val && memreq_rdy;

   assign pop          = run && memresp_val && (count_q != '0);
   assign head_id      = id_fifo_q[rd_ptr_q];
   assign imemresp_val = pop && (head_id == ID_IMEM);
   assign dmemresp_val = pop && (head_id == ID_DMEM);
   assign imemresp_msg = memresp_msg;
   assign dmemresp_msg = memresp_msg;

   // A push never coincides with full, and a pop never with empty, so the
   // count cannot leave 0..MAX_OUTS.
   always_comb begin
      count_d = count_q;
      unique case ({fire, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: the ID storage has no reset; emptiness is defined by the pointers
   // and count alone, which keeps the storage a plain enable-written array.
   always_ff @(posedge clk) begin
      if (run && fire) begin
         id_fifo_q[wr_ptr_q] <= grant;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_ARB;
         last_grant_q <= ID_IMEM;
         hold_id_q    <= ID_IMEM;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         count_q <= count_d;

         if (fire) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (memresp_val && (count_q == '0)) begin
            resp_err_q <= 1'b1;
         end

         unique case (state_q)
            ST_ARB: begin
               if (fire) begin
                  last_grant_q <= grant;
               end else if (grant_val && !full && !memreq_rdy) begin
                  hold_id_q <= grant;
                  state_q   <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (fire) begin
                  last_grant_q <= hold_id_q;
                  state_q      <= ST_ARB;
               end else if (!grant_val) begin
                  state_q <= ST_ARB;
               end
            end
            default: state_q <= ST_ARB;
         endcase
      end
   end

   assign outs_count = count_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_riscv_mem_arbiter;

   localparam int REQ_SZ   = 67;
   localparam int RESP_SZ  = 35;
   localparam int MAX_OUTS = 4;
   localparam int CNT_W    = $clog2(MAX_OUTS) + 1;

   localparam logic [REQ_SZ-1:0]  IMSG = 67'h2_1111_2222_3333_4444;
   localparam logic [REQ_SZ-1:0]  DMSG = 67'h5_aaaa_bbbb_cccc_dddd;
   localparam logic [RESP_SZ-1:0] RMSG = 35'h5_1234_5678;

   logic                clk;
   logic                reset_n;
   logic [REQ_SZ-1:0]   imemreq_msg;
   logic                imemreq_val;
   logic                imemreq_rdy;
   logic [RESP_SZ-1:0]  imemresp_msg;
   logic                imemresp_val;
   logic [REQ_SZ-1:0]   dmemreq_msg;
   logic                dmemreq_val;
   logic                dmemreq_rdy;
   logic [RESP_SZ-1:0]  dmemresp_msg;
   logic                dmemresp_val;
   logic [REQ_SZ-1:0]   memreq_msg;
   logic                memreq_val;
   logic                memreq_rdy;
   logic [RESP_SZ-1:0]  memresp_msg;
   logic                memresp_val;
   logic [CNT_W-1:0]    outs_count;
   logic                resp_err;

   int n_checks = 0;
   int n_errors = 0;

   riscv_mem_arbiter #(
      .REQ_SZ   (REQ_SZ),
      .RESP_SZ  (RESP_SZ),
      .MAX_OUTS (MAX_OUTS)
   ) dut (
      .clk          (clk),
      .reset        (reset_n),
      .imemreq_msg  (imemreq_msg),
      .imemreq_val  (imemreq_val),
      .imemreq_rdy  (imemreq_rdy),
      .imemresp_msg (imemresp_msg),
      .imemresp_val (imemresp_val),
      .dmemreq_msg  (dmemreq_msg),
      .dmemreq_val  (dmemreq_val),
      .dmemreq_rdy  (dmemreq_rdy),
      .dmemresp_msg (dmemresp_msg),
      .dmemresp_val (dmemresp_val),
      .memreq_msg   (memreq_msg),
      .memreq_val   (memreq_val),
      .memreq_rdy   (memreq_rdy),
      .memresp_msg  (memresp_msg),
      .memresp_val  (memresp_val),
      .outs_count   (outs_count),
      .resp_err     (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string name;
      bit    rn;
      bit    iv;
      bit    dv;
      bit    mr;
      bit    rv;
      bit    e_mval;
      bit    e_irdy;
      bit    e_drdy;
      bit    e_gnt_d;
      bit    e_ivr;
      bit    e_dvr;
      int    e_cnt;
      bit    e_err;
   } vec_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input bit rn, iv, dv, mr, rv,
                               input bit em, eir, edr, egd, eiv, edv,
                               input int ec, input bit ee);
      vec_t v;
      v.name = n; v.rn = rn; v.iv = iv; v.dv = dv; v.mr = mr; v.rv = rv;
      v.e_mval = em; v.e_irdy = eir; v.e_drdy = edr; v.e_gnt_d = egd;
      v.e_ivr = eiv; v.e_dvr = edv; v.e_cnt = ec; v.e_err = ee;
      return v;
   endfunction

   // Drive one cycle, check the combinational outputs mid-cycle, then the registered ones after the edge.
   task automatic apply_vec(input vec_t v);
      reset_n     = v.rn;
      imemreq_val = v.iv;
      dmemreq_val = v.dv;
      memreq_rdy  = v.mr;
      memresp_val = v.rv;
      imemreq_msg = IMSG;
      dmemreq_msg = DMSG;
      memresp_msg = RMSG;
      #1;
      check({v.name, ".memreq_val"},   memreq_val,   v.e_mval);
      check({v.name, ".imemreq_rdy"},  imemreq_rdy,  v.e_irdy);
      check({v.name, ".dmemreq_rdy"},  dmemreq_rdy,  v.e_drdy);
      check({v.name, ".imemresp_val"}, imemresp_val, v.e_ivr);
      check({v.name, ".dmemresp_val"}, dmemresp_val, v.e_dvr);
      if (v.e_mval) check({v.name, ".memreq_msg"}, memreq_msg, v.e_gnt_d ? DMSG : IMSG);
      if (v.e_ivr)  check({v.name, ".imemresp_msg"}, imemresp_msg, RMSG);
      if (v.e_dvr)  check({v.name, ".dmemresp_msg"}, dmemresp_msg, RMSG);
      @(posedge clk);
      #1;
      check({v.name, ".outs_count"}, outs_count, v.e_cnt);
      check({v.name, ".resp_err"},   resp_err,   v.e_err);
   endtask

   task automatic run_random(input int cycles);
      bit              q[$];
      int              m_last;
      int              m_lock;
      bit              m_err;
      bit              i_pend, d_pend;
      logic [REQ_SZ-1:0] i_msg, d_msg;
      logic [95:0]     r;
      bit              rn, mr, rv, full, gval, e_mval, e_irdy, e_drdy, fire, pop, head, dc;
      int              gsel;
      logic [RESP_SZ-1:0] rmsg;

      m_last = 0; m_lock = -1; m_err = 1'b0;
      i_pend = 1'b0; d_pend = 1'b0;
      i_msg = '0; d_msg = '0;
      for (int cyc = 0; cyc < cycles; cyc++) begin
         rn = !(cyc == 0 || $urandom_range(0, 79) == 0);
         if (!i_pend && $urandom_range(0, 1) == 1) begin
            i_pend = 1'b1; r = {$urandom, $urandom, $urandom}; i_msg = r[REQ_SZ-1:0];
         end
         if (!d_pend && $urandom_range(0, 1) == 1) begin
            d_pend = 1'b1; r = {$urandom, $urandom, $urandom}; d_msg = r[REQ_SZ-1:0];
         end
         // Occasionally withdraw a request that is being held, to exercise the drop path.
         if (i_pend && m_lock == 0 && $urandom_range(0, 19) == 0) i_pend = 1'b0;
         if (d_pend && m_lock == 1 && $urandom_range(0, 19) == 0) d_pend = 1'b0;
         mr   = ($urandom_range(0, 9) < 7);
         rv   = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
         r    = {$urandom, $urandom, $urandom};
         rmsg = r[RESP_SZ-1:0];

         reset_n = rn; imemreq_val = i_pend; dmemreq_val = d_pend;
         imemreq_msg = i_msg; dmemreq_msg = d_msg;
         memreq_rdy = mr; memresp_val = rv; memresp_msg = rmsg;
         #1;

         full = (q.size() == MAX_OUTS);
         if (m_lock >= 0)             gsel = m_lock;
         else if (i_pend && !d_pend)  gsel = 0;
         else if (d_pend && !i_pend)  gsel = 1;
         else                         gsel = (m_last == 0) ? 1 : 0;
         gval   = (gsel == 0) ? i_pend : d_pend;
         e_mval = rn && gval && !full;
         e_irdy = rn && (gsel == 0) && mr && !full;
         e_drdy = rn && (gsel == 1) && mr && !full;
         fire   = e_mval && mr;
         pop    = rn && rv && (q.size() > 0);
         head   = (q.size() > 0) ? q[0] : 1'b0;
         dc     = rn && !i_pend && !d_pend && (m_lock < 0) && !full;

         check("rand.memreq_val", memreq_val, e_mval);
         if (!dc) begin
            check("rand.imemreq_rdy", imemreq_rdy, e_irdy);
            check("rand.dmemreq_rdy", dmemreq_rdy, e_drdy);
         end
         if (e_mval) check("rand.memreq_msg", memreq_msg, (gsel == 0) ? i_msg : d_msg);
         check("rand.imemresp_val", imemresp_val, pop && (head == 1'b0));
         check("rand.dmemresp_val", dmemresp_val, pop && (head == 1'b1));
         if (pop) check("rand.resp_msg", (head == 1'b0) ? imemresp_msg : dmemresp_msg, rmsg);

         if (!rn) begin
            q.delete(); m_last = 0; m_lock = -1; m_err = 1'b0;
         end else begin
            if (rv && q.size() == 0) m_err = 1'b1;
            if (pop) void'(q.pop_front());
            if (fire) begin
               q.push_back(gsel[0]);
               m_last = gsel; m_lock = -1;
               if (gsel == 0) i_pend = 1'b0; else d_pend = 1'b0;
            end else if (m_lock >= 0 && !gval) begin
               m_lock = -1;
            end else if (m_lock < 0 && gval && !full && !mr) begin
               m_lock = gsel;
            end
         end

         @(posedge clk);
         #1;
         check("rand.outs_count", outs_count, q.size());
         check("rand.resp_err",   resp_err,   m_err);
      end
   endtask

   vec_t tbl[$];

   initial begin
      reset_n = 1'b0; imemreq_val = 1'b0; dmemreq_val = 1'b0; memreq_rdy = 1'b0;
      memresp_val = 1'b0; imemreq_msg = '0; dmemreq_msg = '0; memresp_msg = '0;

      //                name      rn iv dv mr rv  mv ir dr gd iv dv cnt err
      tbl.push_back(mk("rst",     0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("i_only0", 1, 1, 0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk("i_only1", 1, 1, 0, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0));
      tbl.push_back(mk("i_only2", 1, 1, 0, 1, 0,  1, 1, 0, 0, 0, 0, 3, 0));
      tbl.push_back(mk("i_resp0", 1, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 2, 0));
      tbl.push_back(mk("i_resp1", 1, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk("i_resp2", 1, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk("rr0",     1, 1, 1, 1, 0,  1, 0, 1, 1, 0, 0, 1, 0));
      tbl.push_back(mk("rr1",     1, 1, 1, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0));
      tbl.push_back(mk("rr2",     1, 1, 1, 1, 0,  1, 0, 1, 1, 0, 0, 3, 0));
      tbl.push_back(mk("rr3",     1, 1, 1, 1, 0,  1, 1, 0, 0, 0, 0, 4, 0));
      tbl.push_back(mk("rr_rsp0", 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 3, 0));
      tbl.push_back(mk("rr_rsp1", 1, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 2, 0));
      tbl.push_back(mk("rr_rsp2", 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk("rr_rsp3", 1, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk("hold_d0", 1, 1, 1, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk("hold_d1", 1, 1, 1, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk("hold_d2", 1, 1, 1, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk("hold_df", 1, 1, 1, 1, 0,  1, 0, 1, 1, 0, 0, 1, 0));
      tbl.push_back(mk("after_d", 1, 1, 1, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0));
      tbl.push_back(mk("hold_i0", 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 2, 0));
      tbl.push_back(mk("hold_i1", 1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 2, 0));
      tbl.push_back(mk("hold_if", 1, 1, 1, 1, 0,  1, 1, 0, 0, 0, 0, 3, 0));
      tbl.push_back(mk("fill",    1, 1, 1, 1, 0,  1, 0, 1, 1, 0, 0, 4, 0));
      tbl.push_back(mk("full",    1, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 4, 0));
      tbl.push_back(mk("full_pop",1, 1, 1, 1, 1,  0, 0, 0, 0, 0, 1, 3, 0));
      tbl.push_back(mk("push_pop",1, 1, 1, 1, 1,  1, 1, 0, 0, 1, 0, 3, 0));
      tbl.push_back(mk("drain0",  1, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 2, 0));
      tbl.push_back(mk("drain1",  1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk("drain2",  1, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i]);

      // Stray response with nothing outstanding: sticky error, no response routed.
      apply_vec(mk("err_set",  1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1));
      apply_vec(mk("err_keep", 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1));

      // Reset with requests outstanding and a grant held.
      apply_vec(mk("pre_rst0", 1, 1, 0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 1));
      apply_vec(mk("pre_rst1", 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 1));
      apply_vec(mk("mid_rst",  0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0));
      apply_vec(mk("post_err", 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1));
      apply_vec(mk("post_arb", 1, 1, 1, 1, 0,  1, 0, 1, 1, 0, 0, 1, 1));

      // Held requester withdraws its valid: the grant must be released.
      apply_vec(mk("drop0",    1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 1));
      apply_vec(mk("drop1",    1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1));
      apply_vec(mk("drop2",    1, 0, 1, 1, 0,  1, 0, 1, 1, 0, 0, 2, 1));

      run_random(800);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
